// File: rtl/onchip_mem_arbiter_if.sv
// One Avalon-MM data-master port as seen by the on-chip RAM arbiter.
// The core drives the request side (master modport); the arbiter answers (slave modport).
interface onchip_mem_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic [AW-1:0]   address;
  logic [DW/8-1:0] byteenable;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic            lock;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters,
// with a bounded grant lock for atomic sequences and tagged one-cycle read return.
module onchip_mem_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  onchip_mem_arbiter_if.slave  m0,
  onchip_mem_arbiter_if.slave  m1,
  output logic [AW-1:0]        mem_address,
  output logic [DW/8-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DW-1:0]        mem_writedata,
  input  logic [DW-1:0]        mem_readdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_tag_q, rd_tag_d;

  logic            req0, req1;
  logic            gnt_vld, gnt;
  logic            sel_read, sel_write, sel_lock, owner_lock;
  logic [AW-1:0]   sel_address;
  logic [DW/8-1:0] sel_byteenable;
  logic [DW-1:0]   sel_writedata;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // A locked owner is the only candidate; otherwise the tie goes to whoever was not served last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    case (state_q)
      ST_LOCK0: begin gnt_vld = req0; gnt = 1'b0; end
      ST_LOCK1: begin gnt_vld = req1; gnt = 1'b1; end
      default: begin
        gnt_vld = req0 | req1;
        gnt     = (req0 & req1) ? ~last_grant_q : req1;
      end
    endcase
  end

  assign sel_read       = gnt ? m1.read       : m0.read;
  assign sel_write      = gnt ? m1.write      : m0.write;
  assign sel_lock       = gnt ? m1.lock       : m0.lock;
  assign sel_address    = gnt ? m1.address    : m0.address;
  assign sel_byteenable = gnt ? m1.byteenable : m0.byteenable;
  assign sel_writedata  = gnt ? m1.writedata  : m0.writedata;
  assign owner_lock     = (state_q == ST_LOCK1) ? m1.lock : m0.lock;

  assign m0.waitrequest = req0 & ~(gnt_vld & ~gnt);
  assign m1.waitrequest = req1 & ~(gnt_vld &  gnt);

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (gnt_vld && reset_n) begin
      mem_address    = sel_address;
      mem_byteenable = sel_byteenable;
      mem_chipselect = 1'b1;
      mem_write      = sel_write;
      mem_writedata  = sel_writedata;
    end
  end

  // A simultaneous read+write is a write, so it never schedules a read return.
  assign rd_pend_d = gnt_vld & sel_read & ~sel_write;
  assign rd_tag_d  = gnt;

  // The lock window ends on the cycle whose decrement reaches zero, bounding it to LOCK_MAX grants.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      ST_LOCK0, ST_LOCK1: begin
        lock_cnt_d   = (lock_cnt_q != 8'd0) ? lock_cnt_q - 8'd1 : 8'd0;
        last_grant_d = (state_q == ST_LOCK1);
        if (!owner_lock || lock_cnt_q <= 8'd1) state_d = ST_IDLE;
      end
      default: begin
        if (gnt_vld) begin
          last_grant_d = gnt;
          if (sel_lock && LOCK_MAX > 1) begin
            state_d    = gnt ? ST_LOCK1 : ST_LOCK0;
            lock_cnt_d = 8'(LOCK_MAX - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= 8'd0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pend_q    <= rd_pend_d;
    end
    rd_tag_q <= rd_tag_d;
  end

  // Read data is shared; only the valid strobe is steered, and reset suppresses a return in flight.
  assign m0.readdatavalid = reset_n & rd_pend_q & ~rd_tag_q;
  assign m1.readdatavalid = reset_n & rd_pend_q &  rd_tag_q;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomized scoreboard bench for onchip_mem_arbiter: a transaction-level model predicts
// grants and read returns; a separate monitor pops expected returns as the DUT presents them.
module tb_onchip_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  onchip_mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic [AW-1:0]   mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic            mem_chipselect, mem_write;
  logic [DW-1:0]   mem_writedata;
  logic [DW-1:0]   mem_readdata;

  onchip_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata)
  );

  // Physical RAM behind the arbiter.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < DW/8; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  typedef struct {
    logic rd, wr, lk;
    logic [AW-1:0] a;
    logic [DW/8-1:0] be;
    logic [DW-1:0] d;
  } req_t;

  typedef struct {
    int m;
    logic [DW-1:0] d;
    int cyc;
  } rexp_t;

  req_t  p [2];
  rexp_t rq [$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  // Reference arbitration state: lock owner (-1 none), grants left in the window, tie winner.
  int owner = -1, left = 0, prio = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  function automatic req_t idle_req();
    req_t r;
    r.rd = 0; r.wr = 0; r.lk = 0; r.a = '0; r.be = '0; r.d = '0;
    return r;
  endfunction

  function automatic req_t mk(input logic rd, input logic wr, input logic lk,
                              input logic [AW-1:0] a, input logic [DW/8-1:0] be,
                              input logic [DW-1:0] d);
    req_t r;
    r.rd = rd; r.wr = wr; r.lk = lk; r.a = a; r.be = be; r.d = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int k;
    k = $urandom_range(0, 9);
    r.rd = (k >= 3 && k <= 5) || k == 9;
    r.wr = (k >= 6);
    r.lk = ($urandom_range(0, 5) == 0);
    r.a  = AW'($urandom_range(0, 15));
    r.be = 4'($urandom);
    r.d  = $urandom;
    return r;
  endfunction

  // One bus cycle: drive, predict at the falling edge, compare, then advance the model.
  task automatic cycle(input bit rst_c, output int g, output int dg);
    bit r0, r1;
    @(posedge clk);
    #1;
    reset_n = !rst_c;
    if (rst_c) begin
      while (rq.size() > 0 && rq[0].cyc == cyc) void'(rq.pop_front());
    end
    m0_if.read = p[0].rd; m0_if.write = p[0].wr; m0_if.lock = p[0].lk;
    m0_if.address = p[0].a; m0_if.byteenable = p[0].be; m0_if.writedata = p[0].d;
    m1_if.read = p[1].rd; m1_if.write = p[1].wr; m1_if.lock = p[1].lk;
    m1_if.address = p[1].a; m1_if.byteenable = p[1].be; m1_if.writedata = p[1].d;
    @(negedge clk);
    r0 = p[0].rd | p[0].wr;
    r1 = p[1].rd | p[1].wr;
    dg = !mem_chipselect ? -1 : (r0 && !m0_if.waitrequest) ? 0 :
         (r1 && !m1_if.waitrequest) ? 1 : -2;
    if (rst_c) begin
      check("cs_in_reset", mem_chipselect, 1'b0);
      owner = -1; left = 0; prio = 0;
      g = -1;
      return;
    end
    if (owner >= 0) g = (owner == 0 ? r0 : r1) ? owner : -1;
    else if (r0 && r1) g = prio;
    else if (r0) g = 0;
    else if (r1) g = 1;
    else g = -1;

    check("wait0", m0_if.waitrequest, r0 && g != 0);
    check("wait1", m1_if.waitrequest, r1 && g != 1);
    check("chipselect", mem_chipselect, g >= 0);
    if (g >= 0) begin
      check("mem_address", mem_address, p[g].a);
      check("mem_write", mem_write, p[g].wr);
      if (p[g].wr) begin
        check("mem_writedata", mem_writedata, p[g].d);
        check("mem_byteenable", mem_byteenable, p[g].be);
        for (int b = 0; b < DW/8; b++)
          if (p[g].be[b]) ref_mem[p[g].a][b*8 +: 8] = p[g].d[b*8 +: 8];
      end else begin
        rq.push_back('{m: g, d: ref_mem[p[g].a], cyc: cyc + 1});
      end
    end

    if (owner < 0) begin
      if (g >= 0) begin
        prio = 1 - g;
        if (p[g].lk && LOCK_MAX > 1) begin owner = g; left = LOCK_MAX - 1; end
      end
    end else begin
      left--;
      prio = 1 - owner;
      if (left <= 0 || !p[owner].lk) owner = -1;
    end
  endtask

  // Monitor: any read return due this cycle must appear on exactly the issuing master.
  always @(negedge clk) begin
    int m;
    m = (rq.size() > 0 && rq[0].cyc == cyc) ? rq[0].m : -1;
    check("rdv0", m0_if.readdatavalid, m == 0);
    check("rdv1", m1_if.readdatavalid, m == 1);
    if (m >= 0) begin
      check("readdata", (m == 0) ? m0_if.readdata : m1_if.readdata, rq[0].d);
      void'(rq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int g, dg;
    int lock_exp [8];
    for (int i = 0; i < (1<<AW); i++) begin ram[i] = '0; ref_mem[i] = '0; end
    p[0] = idle_req(); p[1] = idle_req();
    cycle(1, g, dg); cycle(1, g, dg);
    check("rdv0_after_reset", m0_if.readdatavalid, 1'b0);

    // Single master write then read-back.
    p[0] = mk(0, 1, 0, 13'h0010, 4'hF, 32'hDEADBEEF);
    cycle(0, g, dg); check("t1_write_grant", dg, 0);
    p[0] = mk(1, 0, 0, 13'h0010, 4'hF, 32'h0);
    cycle(0, g, dg); check("t1_read_grant", dg, 0);
    p[0] = idle_req();
    cycle(0, g, dg);
    check("t1_rdv", m0_if.readdatavalid, 1'b1);
    check("t1_data", m0_if.readdata, 32'hDEADBEEF);

    // Contention right after reset: m0 first, m1 next cycle.
    cycle(1, g, dg);
    p[0] = mk(1, 0, 0, 13'h0010, 4'h0, 32'h0);
    p[1] = mk(1, 0, 0, 13'h0020, 4'h0, 32'h0);
    cycle(0, g, dg); check("t2_first", dg, 0); check("t2_m1_wait", m1_if.waitrequest, 1'b1);
    p[0] = idle_req();
    cycle(0, g, dg); check("t2_second", dg, 1);
    p[1] = idle_req();
    cycle(0, g, dg);

    // Sustained read contention alternates 0,1,0,1,...
    p[0] = mk(1, 0, 0, AW'($urandom_range(0, 31)), 4'h0, 32'h0);
    p[1] = mk(1, 0, 0, AW'($urandom_range(0, 31)), 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, g, dg);
      check("t3_alternate", dg, i % 2);
      if (g >= 0) p[g].a = AW'($urandom_range(0, 31));
    end
    p[0] = idle_req(); p[1] = idle_req();
    cycle(0, g, dg);

    // Byte lanes.
    p[1] = mk(0, 1, 0, 13'h1FFF, 4'hF, 32'hFFFFFFFF); cycle(0, g, dg);
    p[1] = mk(0, 1, 0, 13'h1FFF, 4'h5, 32'h11223344); cycle(0, g, dg);
    p[1] = mk(1, 0, 0, 13'h1FFF, 4'h0, 32'h0);        cycle(0, g, dg);
    p[1] = idle_req();                                cycle(0, g, dg);
    check("t4_rdv", m1_if.readdatavalid, 1'b1);
    check("t4_data", m1_if.readdata, 32'hFF22FF44);

    // Lock window of LOCK_MAX grants, then alternation.
    cycle(1, g, dg);
    lock_exp = '{0, 0, 0, 0, 1, 0, 1, 0};
    begin
      int wn;
      wn = 0;
      p[0] = mk(0, 1, 1, 13'h0100, 4'hF, 32'hA0000000);
      p[1] = mk(1, 0, 0, 13'h0200, 4'h0, 32'h0);
      for (int i = 0; i < 8; i++) begin
        cycle(0, g, dg);
        check("t5_lock_grant", dg, lock_exp[i]);
        if (g == 0) begin
          wn++;
          p[0] = (wn < 6) ? mk(0, 1, wn < 4, AW'(13'h0100 + wn), 4'hF, 32'hA0000000 + wn)
                          : idle_req();
        end
        if (g == 1) p[1].a = p[1].a + 1;
      end
    end
    p[0] = idle_req(); p[1] = idle_req();
    cycle(0, g, dg); cycle(0, g, dg);

    // Reset the cycle after an accepted m1 read: the return is dropped.
    p[1] = mk(1, 0, 0, 13'h0020, 4'h0, 32'h0);
    cycle(0, g, dg); check("t6_read_grant", dg, 1);
    p[1] = idle_req();
    cycle(1, g, dg);
    check("t6_no_rdv1", m1_if.readdatavalid, 1'b0);
    p[0] = mk(1, 0, 0, 13'h0030, 4'h0, 32'h0);
    p[1] = mk(1, 0, 0, 13'h0040, 4'h0, 32'h0);
    cycle(0, g, dg); check("t6_tie_m0", dg, 0);
    p[0] = idle_req();
    cycle(0, g, dg);
    p[1] = idle_req();
    cycle(0, g, dg);

    // Random traffic; a stalled request is held until accepted.
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < 2; n++)
        if (!(p[n].rd | p[n].wr) || g == n) p[n] = rand_req();
      cycle(0, g, dg);
      for (int n = 0; n < 2; n++)
        if (g == n || !(p[n].rd | p[n].wr)) p[n] = rand_req();
      g = -1;
    end
    p[0] = idle_req(); p[1] = idle_req();
    for (int i = 0; i < 4; i++) cycle(0, g, dg);
    check("drain", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
